// File: rtl/cam_seq_pkg.sv
// rtl/cam_seq_pkg.sv - State encodings, default timing and per-state output vectors for the camera sequencer
package cam_seq_pkg;

  // State encodings (3-bit, visible on state_dbg)
  localparam logic [2:0] S_PWDN   = 3'd0;
  localparam logic [2:0] S_CLKON  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_READY  = 3'd5;
  localparam logic [2:0] S_FAIL   = 3'd6;

  // Default timing at 100 MHz
  localparam int DEF_PWDN_CYC    = 100000;    // 1 ms
  localparam int DEF_RST_CYC     = 100000;    // 1 ms
  localparam int DEF_SETTLE_CYC  = 200000;    // 2 ms
  localparam int DEF_CFG_TIMEOUT = 10000000;  // 100 ms
  localparam int DEF_MAX_RETRY   = 3;

  // Output vectors, bit order {pwdn, rst_n, xclk_en, cfg_start, ready, seq_err}
  localparam logic [5:0] OUT_PWDN   = 6'b100000;
  localparam logic [5:0] OUT_CLKON  = 6'b001000;
  localparam logic [5:0] OUT_SETTLE = 6'b011000;
  localparam logic [5:0] OUT_START  = 6'b011100;
  localparam logic [5:0] OUT_WAIT   = 6'b011000;
  localparam logic [5:0] OUT_READY  = 6'b011010;
  localparam logic [5:0] OUT_FAIL   = 6'b100001;

  // Output vector for a given state; unknown encodings look like power-down
  function automatic logic [5:0] state_outs(input logic [2:0] s);
    case (s)
      S_PWDN:   return OUT_PWDN;
      S_CLKON:  return OUT_CLKON;
      S_SETTLE: return OUT_SETTLE;
      S_START:  return OUT_START;
      S_WAIT:   return OUT_WAIT;
      S_READY:  return OUT_READY;
      S_FAIL:   return OUT_FAIL;
      default:  return OUT_PWDN;
    endcase
  endfunction

endpackage

// File: rtl/cam_seq_timer.sv
// rtl/cam_seq_timer.sv - Per-state cycle timer with clear-on-entry and terminal compare
module cam_seq_timer #(
  parameter int W = 24
) (
  input  logic         clk_100,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         hit
);

  logic [W-1:0] cnt;

  // Count cycles since the last state entry; clear takes priority over counting
  always_ff @(posedge clk_100) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign hit = (cnt == term);

endmodule

// File: rtl/cam_pwr_seq.sv
// rtl/cam_pwr_seq.sv - Camera power-up, reset and configuration sequencer with retry and restart
module cam_pwr_seq
  import cam_seq_pkg::*;
#(
  parameter int PWDN_CYC    = DEF_PWDN_CYC,
  parameter int RST_CYC     = DEF_RST_CYC,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int CFG_TIMEOUT = DEF_CFG_TIMEOUT,
  parameter int MAX_RETRY   = DEF_MAX_RETRY,
  parameter int CNT_W       = 24,
  parameter int RTY_W       = 2
) (
  input  logic             clk_100,
  input  logic             rst_n,
  input  logic             restart,
  input  logic             cfg_done,
  input  logic             cfg_err,
  output logic             cam_pwdn,
  output logic             cam_rst_n,
  output logic             xclk_en,
  output logic             cfg_start,
  output logic             ready,
  output logic             seq_err,
  output logic [RTY_W-1:0] retry_cnt,
  output logic [2:0]       state_dbg
);

  // Terminal counts: a state of length N leaves when the timer reads N-1
  localparam logic [CNT_W-1:0] PWDN_TERM   = CNT_W'(PWDN_CYC - 1);
  localparam logic [CNT_W-1:0] RST_TERM    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_TERM   = CNT_W'(CFG_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RETRY_MAX   = RTY_W'(MAX_RETRY);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [RTY_W-1:0] retry_nxt;
  logic             enter;
  logic             tmr_en;
  logic             tmr_hit;
  logic [CNT_W-1:0] tmr_term;

  cam_seq_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk_100 (clk_100),
    .rst_n   (rst_n),
    .clr     (enter),
    .en      (tmr_en),
    .term    (tmr_term),
    .hit     (tmr_hit)
  );

  // Select the terminal count for the current timed state; the terminal states stop the timer
  always_comb begin
    tmr_term = '0;
    tmr_en   = 1'b1;
    case (state)
      S_PWDN:   tmr_term = PWDN_TERM;
      S_CLKON:  tmr_term = RST_TERM;
      S_SETTLE: tmr_term = SETTLE_TERM;
      S_WAIT:   tmr_term = WAIT_TERM;
      S_READY:  tmr_en   = 1'b0;
      S_FAIL:   tmr_en   = 1'b0;
      default:  tmr_term = '0;
    endcase
  end

  // Next-state and retry decision; restart forces a fresh power cycle from any state
  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    enter     = 1'b0;
    if (restart) begin
      state_nxt = S_PWDN;
      retry_nxt = '0;
      enter     = 1'b1;
    end else begin
      case (state)
        S_PWDN: begin
          if (tmr_hit) begin
            state_nxt = S_CLKON;
            enter     = 1'b1;
          end
        end
        S_CLKON: begin
          if (tmr_hit) begin
            state_nxt = S_SETTLE;
            enter     = 1'b1;
          end
        end
        S_SETTLE: begin
          if (tmr_hit) begin
            state_nxt = S_START;
            enter     = 1'b1;
          end
        end
        S_START: begin
          state_nxt = S_WAIT;
          enter     = 1'b1;
        end
        S_WAIT: begin
          // Error beats done; done beats a timeout landing on the same edge
          if (cfg_err || (!cfg_done && tmr_hit)) begin
            enter = 1'b1;
            if (retry_cnt < RETRY_MAX) begin
              state_nxt = S_PWDN;
              retry_nxt = retry_cnt + RTY_W'(1);
            end else begin
              state_nxt = S_FAIL;
            end
          end else if (cfg_done) begin
            state_nxt = S_READY;
            enter     = 1'b1;
          end
        end
        S_READY: state_nxt = S_READY;
        S_FAIL:  state_nxt = S_FAIL;
        default: begin
          state_nxt = S_PWDN;
          enter     = 1'b1;
        end
      endcase
    end
  end

  // State, retry count and all camera-facing outputs are registered together
  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      state     <= S_PWDN;
      retry_cnt <= '0;
      {cam_pwdn, cam_rst_n, xclk_en, cfg_start, ready, seq_err} <= OUT_PWDN;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_nxt;
      {cam_pwdn, cam_rst_n, xclk_en, cfg_start, ready, seq_err} <= state_outs(state_nxt);
    end
  end

  assign state_dbg = state;

endmodule
